// File: rtl/uart_pkg.sv
// Shared UART link definitions: retransmit sequencer state encoding and default acknowledge byte.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    SEND     = 3'd1,
    TX_BUSY  = 3'd2,
    TX_DRAIN = 3'd3,
    ACK_WAIT = 3'd4
  } uart_retx_state_t;

  localparam logic [7:0] UART_ACK_BYTE = 8'hCC;

endpackage

// File: rtl/uart_ack_timer.sv
// Clearable acknowledge-wait up-counter; flags the last cycle of the wait window and holds there.
module uart_ack_timer #(
  parameter int unsigned ACK_TIMEOUT = 10000,
  localparam int unsigned TW = ($clog2(ACK_TIMEOUT) > 0) ? $clog2(ACK_TIMEOUT) : 1
) (
  input  logic clk,
  input  logic rst,
  input  logic clr_i,
  input  logic en_i,
  output logic tc_c_o
);

  logic [TW-1:0] count_q;
  logic [TW-1:0] count_d;

  assign tc_c_o = (count_q == TW'(ACK_TIMEOUT - 1));

  always_comb begin
    count_d = count_q;
    if (clr_i) begin
      count_d = '0;
    end else if (en_i && !tc_c_o) begin
      count_d = count_q + TW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/uart_retx_ctrl.sv
// Acknowledged-delivery transmit sequencer: sends one byte through the UART transmitter,
// waits for the acknowledge byte from the receiver and retransmits on timeout.
module uart_retx_ctrl
  import uart_pkg::*;
#(
  parameter int unsigned DATA_WIDTH       = 8,
  parameter int unsigned ACK_TIMEOUT      = 10000,
  parameter int unsigned RETRANSMIT_TIMES = 3,
  parameter logic [DATA_WIDTH-1:0] ACK_BYTE = DATA_WIDTH'(UART_ACK_BYTE),
  localparam int unsigned RW = ($clog2(RETRANSMIT_TIMES + 1) > 0) ? $clog2(RETRANSMIT_TIMES + 1) : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  input  logic [DATA_WIDTH-1:0] req_data,
  output logic                  req_ready,
  output logic                  done,
  output logic                  fail,
  output logic                  txStart,
  output logic [DATA_WIDTH-1:0] byteForTx,
  input  logic                  txReady,
  input  logic                  rxDone,
  input  logic [DATA_WIDTH-1:0] byteFromRx,
  output logic [RW-1:0]         retry_count,
  output logic [2:0]            state_out
);

  uart_retx_state_t      state_q, state_d;
  logic [DATA_WIDTH-1:0] byte_q, byte_d;
  logic [RW-1:0]         retry_q, retry_d;
  logic                  done_q, done_d;
  logic                  fail_q, fail_d;
  logic                  tx_start_c;
  logic                  tmr_clr;
  logic                  tmr_en;
  logic                  tmr_tc;

  uart_ack_timer #(
    .ACK_TIMEOUT(ACK_TIMEOUT)
  ) u_ack_timer (
    .clk   (clk),
    .rst   (rst),
    .clr_i (tmr_clr),
    .en_i  (tmr_en),
    .tc_c_o(tmr_tc)
  );

  // Next-state and pulse decode; an ACK in the terminal timer cycle wins over the timeout.
  always_comb begin
    state_d    = state_q;
    byte_d     = byte_q;
    retry_d    = retry_q;
    done_d     = 1'b0;
    fail_d     = 1'b0;
    tx_start_c = 1'b0;
    tmr_clr    = 1'b0;
    tmr_en     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (req_valid) begin
          byte_d  = req_data;
          retry_d = '0;
          state_d = SEND;
        end
      end
      SEND: begin
        tx_start_c = txReady;
        if (txReady) begin
          state_d = TX_BUSY;
        end
      end
      TX_BUSY: begin
        if (!txReady) begin
          state_d = TX_DRAIN;
        end
      end
      TX_DRAIN: begin
        if (txReady) begin
          tmr_clr = 1'b1;
          state_d = ACK_WAIT;
        end
      end
      ACK_WAIT: begin
        tmr_en = 1'b1;
        if (rxDone && (byteFromRx == ACK_BYTE)) begin
          done_d  = 1'b1;
          state_d = IDLE;
        end else if (tmr_tc) begin
          if (retry_q < RW'(RETRANSMIT_TIMES)) begin
            retry_d = retry_q + RW'(1);
            state_d = SEND;
          end else begin
            fail_d  = 1'b1;
            state_d = IDLE;
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      byte_q  <= '0;
      retry_q <= '0;
      done_q  <= 1'b0;
      fail_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      byte_q  <= byte_d;
      retry_q <= retry_d;
      done_q  <= done_d;
      fail_q  <= fail_d;
    end
  end

  assign req_ready   = (state_q == IDLE);
  assign txStart     = tx_start_c;
  assign byteForTx   = byte_q;
  assign done        = done_q;
  assign fail        = fail_q;
  assign retry_count = retry_q;
  assign state_out   = 3'(state_q);

endmodule

// File: tb/tb_uart_retx_ctrl.sv
// Bench for uart_retx_ctrl: scenario table, reset-abort sequence and a randomized run
// compared against a timeline reference built from the recorded input history.
module tb_uart_retx_ctrl;

  localparam int TMO    = 20;
  localparam int RTX    = 2;
  localparam int TX_LOW = 10;
  localparam int NR     = 3000;
  localparam logic [7:0] ACK = 8'hCC;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       req_valid = 1'b0;
  logic [7:0] req_data = 8'h00;
  logic       rxDone = 1'b0;
  logic [7:0] byteFromRx = 8'h00;
  logic       req_ready, done, fail, txStart, txReady;
  logic [7:0] byteForTx;
  logic [1:0] retry_count;
  logic [2:0] state_out;

  int tx_busy = 0;
  bit tx_stall = 1'b0;
  assign txReady = (tx_busy == 0) && !tx_stall;

  always #5 clk = ~clk;

  uart_retx_ctrl #(
    .DATA_WIDTH(8),
    .ACK_TIMEOUT(TMO),
    .RETRANSMIT_TIMES(RTX),
    .ACK_BYTE(8'hCC)
  ) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_data(req_data), .req_ready(req_ready),
    .done(done), .fail(fail),
    .txStart(txStart), .byteForTx(byteForTx), .txReady(txReady),
    .rxDone(rxDone), .byteFromRx(byteFromRx),
    .retry_count(retry_count), .state_out(state_out)
  );

  int n_chk = 0;
  int n_err = 0;
  int cyc = 0;
  int last_c = 0;
  bit s_rr, s_start, s_done, s_fail;
  int s_retry, s_byte, s_state;

  bit         rec = 1'b0;
  int         rec_i = 0;
  bit         r_rv [NR];
  logic [7:0] r_rd [NR];
  bit         r_rdy[NR];
  bit         r_rxd[NR];
  logic [7:0] r_rxb[NR];
  int         r_out[NR];
  bit         e_rr[NR], e_start[NR], e_done[NR], e_fail[NR];
  int         e_retry[NR], e_byte[NR];

  typedef struct {
    logic [7:0] data;
    int stall;
    int early_off;
    int wr_att;
    int wr_off;
    logic [7:0] wr_byte;
    int ack_att;
    int ack_off;
    int exp_tx;
    int exp_done;
    int exp_fail;
    int exp_retry;
    int exp_first;
  } scen_t;

  scen_t tbl[8];

  function automatic scen_t mk(logic [7:0] data, int stall, int early_off, int wr_att, int wr_off,
                               logic [7:0] wr_byte, int ack_att, int ack_off, int exp_tx,
                               int exp_done, int exp_fail, int exp_retry, int exp_first);
    scen_t s;
    s.data = data; s.stall = stall; s.early_off = early_off; s.wr_att = wr_att;
    s.wr_off = wr_off; s.wr_byte = wr_byte; s.ack_att = ack_att; s.ack_off = ack_off;
    s.exp_tx = exp_tx; s.exp_done = exp_done; s.exp_fail = exp_fail;
    s.exp_retry = exp_retry; s.exp_first = exp_first;
    return s;
  endfunction

  function automatic int pack(bit rr, bit st, bit dn, bit fl, int retry, int b);
    logic [1:0] r2;
    logic [7:0] b8;
    r2 = 2'(retry);
    b8 = 8'(b);
    return int'({rr, st, dn, fl, r2, b8});
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // One clock cycle: sample outputs mid-cycle, take the edge, then advance the transmitter model.
  task automatic cycle();
    #2;
    s_rr = req_ready; s_start = txStart; s_done = done; s_fail = fail;
    s_retry = int'(retry_count); s_byte = int'(byteForTx); s_state = int'(state_out);
    last_c = cyc;
    if (rec && rec_i < NR) begin
      r_rv[rec_i] = req_valid; r_rd[rec_i] = req_data; r_rdy[rec_i] = txReady;
      r_rxd[rec_i] = rxDone; r_rxb[rec_i] = byteFromRx;
      r_out[rec_i] = pack(s_rr, s_start, s_done, s_fail, s_retry, s_byte);
      rec_i++;
    end
    @(posedge clk);
    #1;
    if (tx_busy > 0) tx_busy--;
    if (s_start) tx_busy = TX_LOW;
    cyc++;
  endtask

  task automatic run_txn(input int id, input scen_t sc);
    int a, s_prev, attempt, ack_c, wr_c, early_c, n_tx, n_done, n_fail, end_c, exp_end, rr_bad, w;
    bit fin;
    attempt = -1; ack_c = -1; wr_c = -1; early_c = -1; n_tx = 0; n_done = 0; n_fail = 0;
    end_c = -1; exp_end = -2; rr_bad = 0; fin = 1'b0; s_prev = 0;
    tx_stall = (sc.stall > 0);
    req_valid = 1'b1; req_data = sc.data; rxDone = 1'b0;
    a = cyc;
    cycle();
    chk($sformatf("s%0d accept_ready", id), int'(s_rr), 1);
    req_valid = 1'b0;
    for (int k = 0; k < 300 && !fin; k++) begin
      if (sc.stall > 0 && cyc >= a + sc.stall) tx_stall = 1'b0;
      rxDone = (cyc == ack_c) || (cyc == wr_c) || (cyc == early_c);
      byteFromRx = (cyc == wr_c) ? sc.wr_byte : ACK;
      cycle();
      if (s_start) begin
        attempt++; n_tx++;
        chk($sformatf("s%0d tx_byte", id), s_byte, int'(sc.data));
        chk($sformatf("s%0d tx_retry", id), s_retry, attempt);
        chk($sformatf("s%0d tx_state", id), s_state, 1);
        if (attempt == 0) chk($sformatf("s%0d first_tx_delay", id), last_c - a, sc.exp_first);
        else chk($sformatf("s%0d retx_gap", id), last_c - s_prev, 12 + TMO);
        s_prev = last_c;
        w = last_c + 12;
        if (attempt == 0 && sc.early_off >= 0) early_c = last_c + sc.early_off;
        if (attempt == sc.ack_att) ack_c = w + sc.ack_off;
        if (attempt == sc.wr_att) wr_c = w + sc.wr_off;
        exp_end = (attempt == sc.ack_att && sc.ack_off < TMO) ? ack_c + 1 : w + TMO;
      end else if (!s_done && !s_fail && s_rr) begin
        rr_bad++;
      end
      if (last_c == ack_c && sc.ack_off < TMO) chk($sformatf("s%0d ack_state", id), s_state, 4);
      if (s_done || s_fail) begin
        fin = 1'b1; end_c = last_c; n_done = int'(s_done); n_fail = int'(s_fail);
      end
    end
    rxDone = 1'b0; tx_stall = 1'b0;
    chk($sformatf("s%0d finished", id), int'(fin), 1);
    chk($sformatf("s%0d tx_count", id), n_tx, sc.exp_tx);
    chk($sformatf("s%0d done", id), n_done, sc.exp_done);
    chk($sformatf("s%0d fail", id), n_fail, sc.exp_fail);
    chk($sformatf("s%0d end_cycle", id), end_c, exp_end);
    chk($sformatf("s%0d busy_ready", id), rr_bad, 0);
    chk($sformatf("s%0d end_retry", id), s_retry, sc.exp_retry);
    cycle();
    chk($sformatf("s%0d hold_retry", id), s_retry, sc.exp_retry);
    chk($sformatf("s%0d hold_pulses", id), int'(s_done) + int'(s_fail), 0);
  endtask

  task automatic fill(input int c, input int retry, input int bytev, input bit rr, input bit st);
    if (c >= 0 && c < NR) begin
      e_rr[c] = rr; e_start[c] = st; e_retry[c] = retry; e_byte[c] = bytev;
    end
  endtask

  // Expected outputs walked along the recorded input timeline, one delivery attempt at a time.
  task automatic build_expect(input int n);
    int t, p, retry, bytev;
    bit acked, stop;
    for (int i = 0; i < NR; i++) begin
      e_done[i] = 1'b0; e_fail[i] = 1'b0;
    end
    t = 0; retry = 0; bytev = 0;
    while (t < n) begin
      fill(t, retry, bytev, 1'b1, 1'b0);
      if (!r_rv[t]) begin
        t++;
      end else begin
        bytev = int'(r_rd[t]); retry = 0; p = t + 1; stop = 1'b0;
        while (!stop) begin
          while (p < n && !r_rdy[p]) begin fill(p, retry, bytev, 1'b0, 1'b0); p++; end
          fill(p, retry, bytev, 1'b0, 1'b1); p++;
          while (p < n && r_rdy[p]) begin fill(p, retry, bytev, 1'b0, 1'b0); p++; end
          fill(p, retry, bytev, 1'b0, 1'b0); p++;
          while (p < n && !r_rdy[p]) begin fill(p, retry, bytev, 1'b0, 1'b0); p++; end
          fill(p, retry, bytev, 1'b0, 1'b0); p++;
          acked = 1'b0;
          for (int j = 0; j < TMO && !acked; j++) begin
            fill(p, retry, bytev, 1'b0, 1'b0);
            if (p < n && r_rxd[p] && r_rxb[p] == ACK) acked = 1'b1;
            p++;
          end
          if (acked) begin
            if (p < NR) e_done[p] = 1'b1;
            t = p; stop = 1'b1;
          end else if (retry < RTX) begin
            retry++;
          end else begin
            if (p < NR) e_fail[p] = 1'b1;
            t = p; stop = 1'b1;
          end
          if (p >= n) begin t = n; stop = 1'b1; end
        end
      end
    end
  endtask

  initial begin
    int n, s2, pulses, rr_low;

    tbl[0] = mk(8'hA5, 0, -1, -1, 0, 8'h00,  0,  5, 1, 1, 0, 0, 1);
    tbl[1] = mk(8'h3C, 0, -1, -1, 0, 8'h00, -1,  0, 3, 0, 1, 2, 1);
    tbl[2] = mk(8'h11, 0, -1,  0, 3, 8'h55,  0, 10, 1, 1, 0, 0, 1);
    tbl[3] = mk(8'h5A, 0,  5, -1, 0, 8'h00,  0, 19, 1, 1, 0, 0, 1);
    tbl[4] = mk(8'h96, 0, -1, -1, 0, 8'h00,  1,  0, 2, 1, 0, 1, 1);
    tbl[5] = mk(8'hE7, 0, -1, -1, 0, 8'h00,  2, 19, 3, 1, 0, 2, 1);
    tbl[6] = mk(8'h42, 0, -1,  1, 4, 8'hCD,  0, 20, 3, 0, 1, 2, 1);
    tbl[7] = mk(8'h7E, 15, -1, -1, 0, 8'h00, 0,  2, 1, 1, 0, 0, 15);

    rst = 1'b1;
    cycle();
    cycle();
    chk("rst req_ready", int'(s_rr), 1);
    chk("rst txStart", int'(s_start), 0);
    chk("rst byteForTx", s_byte, 0);
    chk("rst done_fail", int'(s_done) + int'(s_fail), 0);
    chk("rst retry", s_retry, 0);
    chk("rst state", s_state, 0);
    rst = 1'b0;
    cycle();
    chk("post_rst state", s_state, 0);

    for (int i = 0; i < 8; i++) run_txn(i, tbl[i]);

    // Reset while waiting for the ACK of the first retransmission.
    req_valid = 1'b1; req_data = 8'hB4;
    cycle();
    req_valid = 1'b0;
    n = 0; s2 = -1;
    for (int k = 0; k < 200 && s2 < 0; k++) begin
      cycle();
      if (s_start) begin
        n++;
        if (n == 2) s2 = last_c;
      end
    end
    chk("rstseq two_starts", n, 2);
    for (int k = 0; k < 40 && cyc < s2 + 17; k++) cycle();
    chk("rstseq pre_retry", s_retry, 1);
    chk("rstseq pre_state", s_state, 4);
    rst = 1'b1;
    cycle();
    chk("rstseq ready", int'(s_rr), 1);
    chk("rstseq retry", s_retry, 0);
    chk("rstseq byte", s_byte, 0);
    chk("rstseq pulses", int'(s_done) + int'(s_fail), 0);
    chk("rstseq state", s_state, 0);
    rst = 1'b0;
    pulses = 0; rr_low = 0;
    for (int k = 0; k < 25; k++) begin
      cycle();
      pulses += int'(s_done) + int'(s_fail);
      if (!s_rr) rr_low++;
    end
    chk("rstseq quiet_pulses", pulses, 0);
    chk("rstseq stay_idle", rr_low, 0);

    // Randomized traffic, recorded and checked afterwards against the timeline model.
    rec = 1'b1; rec_i = 0;
    for (int k = 0; k < NR; k++) begin
      req_valid  = ($urandom % 3) == 0;
      req_data   = 8'($urandom);
      rxDone     = ($urandom % 12) == 0;
      byteFromRx = (($urandom % 3) == 0) ? ACK : 8'($urandom);
      tx_stall   = ($urandom % 5) == 0;
      cycle();
    end
    rec = 1'b0;
    req_valid = 1'b0; rxDone = 1'b0; tx_stall = 1'b0;
    build_expect(rec_i);
    for (int i = 0; i < rec_i; i++) begin
      chk($sformatf("rand c%0d {rdy,start,done,fail,retry,byte}", i), r_out[i],
          pack(e_rr[i], e_start[i], e_done[i], e_fail[i], e_retry[i], e_byte[i]));
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/uart_retx_ctrl.md
# uart_retx_ctrl

Transmit-side sequencer for one UART byte link with acknowledged delivery. Accepts one byte from a user-side valid/ready handshake and drives it into a `uart_transmitter`. It then watches the paired `uart_receiver` for the acknowledge byte and retransmits on timeout, up to a fixed retry budget. It sits between a slave/master protocol FSM and its UART transmitter/receiver pair, alongside the shared `uart_baudRateGen`.

## Interface
- `DATA_WIDTH`, 8: UART byte width.
- `ACK_TIMEOUT`, 10000: clk cycles spent in ACK_WAIT before declaring a timeout; must be ≥2.
- `RETRANSMIT_TIMES`, 3: retransmissions after the first attempt; total attempts = 1+RETRANSMIT_TIMES.
- `ACK_BYTE`, 8'hCC: byte value the far end returns as acknowledge.

- `clk` in 1: single clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `req_valid` in 1: user has a byte to send.
- `req_data` in DATA_WIDTH: byte to send; sampled on accept.
- `req_ready` out 1: high only in IDLE.
- `done` out 1: one-cycle pulse; ACK received.
- `fail` out 1: one-cycle pulse; retry budget exhausted.
- `txStart` out 1: start pulse to transmitter.
- `byteForTx` out DATA_WIDTH: byte presented to transmitter.
- `txReady` in 1: transmitter idle.
- `rxDone` in 1: receiver one-cycle new-byte strobe.
- `byteFromRx` in DATA_WIDTH: received byte, valid with `rxDone`.
- `retry_count` out $clog2(RETRANSMIT_TIMES+1): retransmissions made for the current byte.
- `state_out` out 3: encoded current state (debug).

## Operation
- States: IDLE, SEND, TX_BUSY, TX_DRAIN, ACK_WAIT.
- IDLE: `req_ready`=1. On `req_valid`, latch `req_data` into `byteForTx`, clear `retry_count`, go to SEND.
- SEND: `txStart`=`txReady`, combinational. When `txReady`=1, go to TX_BUSY. Otherwise stay in SEND; `txStart` stays 0.
- TX_BUSY: wait for `txReady`=0, then go to TX_DRAIN.
- TX_DRAIN: wait for `txReady`=1, which marks the end of the stop bit. Then clear the timer and go to ACK_WAIT.
- ACK_WAIT: the timer increments every cycle.
  - `rxDone` with `byteFromRx`==ACK_BYTE: pulse `done`, go to IDLE.
  - `rxDone` with any other byte: ignored.
  - Timer==ACK_TIMEOUT-1 with no ACK and `retry_count`<RETRANSMIT_TIMES: increment `retry_count`, go to SEND with the same `byteForTx`.
  - Timer==ACK_TIMEOUT-1 with no ACK and `retry_count`==RETRANSMIT_TIMES: pulse `fail`, go to IDLE.
- `rxDone` outside ACK_WAIT is ignored, including an early ACK during transmission.
- ACK and timeout in the same cycle: ACK wins (`done`, no retry).
- Timer width is $clog2(ACK_TIMEOUT). The timer saturates by construction because it always leaves ACK_WAIT at ACK_TIMEOUT-1.
- `byteForTx` is held stable from accept until the next accept.

## Timing
- Reset values: state IDLE, `req_ready`=1, `txStart`=0, `byteForTx`=0, `done`=0, `fail`=0, `retry_count`=0, timer 0.
- `rst` mid-operation aborts immediately to IDLE. No `done` or `fail` is produced, and the transmitter's in-flight frame is not tracked.
- Accept edge = cycle 0. SEND is entered in cycle 1. `txStart` is high in cycle 1 if `txReady`=1, and is exactly one cycle wide.
- An ACK is honoured in any of the ACK_TIMEOUT cycles of ACK_WAIT.
- A retransmission's `txStart` occurs 1 cycle after the timeout cycle, provided `txReady`=1.
- `done`/`fail` are registered and high in the first IDLE cycle.
- `req_ready` is also high in that cycle, so back-to-back accept is allowed. Accepting in that cycle clears `retry_count`.
- `retry_count` holds its final value in IDLE until the next accept.

## Structure
- Shared package `uart_pkg`: state enum `uart_retx_state_t` (IDLE, SEND, TX_BUSY, TX_DRAIN, ACK_WAIT) and default constant `UART_ACK_BYTE`=8'hCC. `state_out` is the enum cast to 3 bits.
- One natural sub-module: `uart_ack_timer`, a clearable up-counter with a terminal-count flag at ACK_TIMEOUT-1. All other logic is a single FSM.

## Test plan
Bench parameters: ACK_TIMEOUT=20, RETRANSMIT_TIMES=2. A behavioural transmitter drops `txReady` 1 cycle after `txStart` and holds it low for 10 cycles.
- Send 8'hA5; ACK 8'hCC arrives 5 cycles into ACK_WAIT → one `txStart` with `byteForTx`=A5, `done` pulse, `retry_count`=0, `fail` never high.
- Send 8'h3C; no ACK → 3 `txStart` pulses spaced by TX time plus 20-cycle timeouts, `retry_count` 0→1→2, `fail` pulse after the third timeout, no `done`.
- Send 8'h11; wrong byte 8'h55 at cycle 3, then CC at cycle 10 of the first ACK_WAIT → 55 ignored, `done`, single transmission.
- CC on `rxDone` during TX_DRAIN, and CC coincident with timer=19 → the first is ignored; the second yields `done` with no retransmit.
- `txReady` held low on accept of 8'h7E for 15 cycles → `txStart` first asserts in the cycle `txReady` rises; `req_ready`=0 throughout.
- Assert `rst` in ACK_WAIT after one retry → next cycle: IDLE, `req_ready`=1, `retry_count`=0, `byteForTx`=0, no `done`/`fail` pulse.
